// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

  localparam int MEM_ADDR_W         = 32;
  localparam int INST_W             = 32;
  localparam int DEFAULT_INDEX_BITS = 6;

  // Addresses at or above this limit are fetched straight from memory, never cached.
  localparam logic [MEM_ADDR_W-1:0] CACHE_LIMIT = 32'h0002_0000;

  typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
  typedef logic [INST_W-1:0]     inst_t;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_WAIT = 2'd1,
    IC_FILL = 2'd2
  } ic_state_e;

  function automatic logic is_cacheable(input mem_addr_t addr);
    return addr < CACHE_LIMIT;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read, single write port, synchronous bulk
// valid clear (clear dominates a same-cycle write). No backpressure.
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
  parameter int TAG_BITS   = 16 - INDEX_BITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output inst_t                 rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  inst_t                 wr_data,
  input  logic                  clear
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  inst_t               data [LINES];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (clear) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is only visible through its valid bit.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = data[rd_index];

endmodule

// File: rtl/icache.sv
// Instruction cache controller: hit answers in 1 cycle, miss does one 32-bit read on the
// shared memory port; waits while ram_busy is high, and all state freezes while rdy is low.
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
  parameter int TAG_BITS   = 16 - INDEX_BITS
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      rdy,
  input  logic      if_read,
  input  mem_addr_t if_addr,
  input  logic      abort,
  input  logic      flush,
  output logic      if_busy,
  output logic      if_ready,
  output inst_t     if_data,
  input  logic      ram_busy,
  output logic      ram_read,
  output mem_addr_t ram_addr,
  input  logic      ram_ready,
  input  inst_t     ram_data
);

  ic_state_e               state;
  logic [MEM_ADDR_W-1:2]   addr_q;
  logic                    drop;
  logic                    inv_pend;
  mem_addr_t               fill_addr;

  logic                    rd_valid;
  logic [TAG_BITS-1:0]     rd_tag;
  inst_t                   rd_data;
  logic                    hit;
  logic                    wr_en;
  logic                    clear;

  assign fill_addr = {addr_q, 2'b00};
  assign hit       = rd_valid && (rd_tag == if_addr[INDEX_BITS+2 +: TAG_BITS])
                     && is_cacheable(if_addr);
  assign clear     = rdy && flush;
  // A flush landing in the ram_ready cycle also suppresses the install.
  assign wr_en     = rdy && (state == IC_FILL) && ram_ready && !inv_pend && !flush
                     && is_cacheable(fill_addr);

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clock    (clock),
    .reset    (reset),
    .rd_index (if_addr[INDEX_BITS+1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (addr_q[INDEX_BITS+1:2]),
    .wr_tag   (addr_q[INDEX_BITS+2 +: TAG_BITS]),
    .wr_data  (ram_data),
    .clear    (clear)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IC_IDLE;
      addr_q   <= '0;
      drop     <= 1'b0;
      inv_pend <= 1'b0;
      if_busy  <= 1'b0;
      if_ready <= 1'b0;
      if_data  <= '0;
      ram_read <= 1'b0;
      ram_addr <= '0;
    end else if (rdy) begin
      if_ready <= 1'b0;
      case (state)
        IC_IDLE: begin
          if (if_read && !flush && !abort) begin
            if (hit) begin
              if_ready <= 1'b1;
              if_data  <= rd_data;
            end else begin
              addr_q   <= if_addr[MEM_ADDR_W-1:2];
              drop     <= 1'b0;
              inv_pend <= 1'b0;
              if_busy  <= 1'b1;
              state    <= IC_WAIT;
            end
          end
        end
        IC_WAIT: begin
          if (abort) drop <= 1'b1;
          if (flush) inv_pend <= 1'b1;
          if (!ram_busy) begin
            ram_read <= 1'b1;
            ram_addr <= fill_addr;
            state    <= IC_FILL;
          end
        end
        IC_FILL: begin
          if (abort) drop <= 1'b1;
          if (flush) inv_pend <= 1'b1;
          if (ram_ready) begin
            if_data  <= ram_data;
            if_ready <= !drop && !abort;
            if_busy  <= 1'b0;
            ram_read <= 1'b0;
            state    <= IC_IDLE;
          end
        end
        default: begin
          state    <= IC_IDLE;
          if_busy  <= 1'b0;
          ram_read <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Randomized scoreboard bench for icache against a line-level cache model and a
// latency-programmable memory responder.
module tb_icache;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rdy = 1'b1;
  logic        if_read = 1'b0;
  logic [31:0] if_addr = '0;
  logic        abort = 1'b0;
  logic        flush = 1'b0;
  logic        if_busy;
  logic        if_ready;
  logic [31:0] if_data;
  logic        ram_busy = 1'b0;
  logic        ram_read;
  logic [31:0] ram_addr;
  logic        ram_ready = 1'b0;
  logic [31:0] ram_data = '0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int mem_lat = 1;

  logic [31:0] exp_d [$];
  int          exp_c [$];
  logic [31:0] ram_q [$];

  // Model: 64 lines, valid bit plus full tag (address / 256) per line.
  bit          mv [64];
  logic [31:0] mt [64];

  icache dut (
    .clock     (clock),
    .reset     (reset),
    .rdy       (rdy),
    .if_read   (if_read),
    .if_addr   (if_addr),
    .abort     (abort),
    .flush     (flush),
    .if_busy   (if_busy),
    .if_ready  (if_ready),
    .if_data   (if_data),
    .ram_busy  (ram_busy),
    .ram_read  (ram_read),
    .ram_addr  (ram_addr),
    .ram_ready (ram_ready),
    .ram_data  (ram_data)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
  endtask

  // Scoreboard monitor: every if_ready pulse must match the oldest expected response.
  logic [31:0] mon_d;
  int          mon_c;
  always @(negedge clock) begin
    if (!reset && if_ready) begin
      tests++;
      if (exp_d.size() == 0) begin
        fails++;
        $display("FAIL if_ready_unexpected: got pulse with data %h, required no pulse", if_data);
      end else begin
        mon_d = exp_d.pop_front();
        mon_c = exp_c.pop_front();
        if (if_data !== mon_d || cyc != mon_c || if_busy !== 1'b0) begin
          fails++;
          $display("FAIL if_ready_resp: got data %h cycle %0d busy %b, required data %h cycle %0d busy 0",
                   if_data, cyc, if_busy, mon_d, mon_c);
        end
      end
    end
  end

  // Memory responder: ram_ready arrives mem_lat rdy-active cycles after ram_read is seen.
  initial begin
    int          n;
    bit          ab;
    logic [31:0] ea;
    forever begin
      @(negedge clock);
      if (ram_read && !reset) begin
        tests++;
        if (ram_q.size() == 0) begin
          fails++;
          $display("FAIL ram_read_unexpected: got read of %h, required no read", ram_addr);
        end else begin
          ea = ram_q.pop_front();
          if (ram_addr !== ea || if_busy !== 1'b1) begin
            fails++;
            $display("FAIL ram_read_addr: got addr %h busy %b, required addr %h busy 1",
                     ram_addr, if_busy, ea);
          end
        end
        n  = 0;
        ab = 1'b0;
        while (n < mem_lat - 1) begin
          @(posedge clock);
          if (reset) begin ab = 1'b1; break; end
          if (rdy) n++;
        end
        if (!ab) begin
          #1;
          ram_ready = 1'b1;
          ram_data  = mem_word(ram_addr);
          forever begin
            @(posedge clock);
            if (rdy || reset) break;
          end
          #1 ram_ready = 1'b0;
        end
      end
    end
  end

  // Issue one fetch starting in this cycle; DUT is assumed idle.
  task automatic issue(input logic [31:0] a, input int b, input int l, input bit deliver,
                       input bit install, input int extra, output bit hit);
    int          idx;
    logic [31:0] tg;
    bit          cach;
    cach = (a < 32'h0002_0000);
    idx  = int'((a >> 2) % 64);
    tg   = a >> 8;
    hit  = cach && mv[idx] && (mt[idx] == tg);
    if (deliver) begin
      exp_d.push_back(mem_word(a & ~32'h3));
      exp_c.push_back(hit ? cyc + 1 : cyc + 2 + b + l + extra);
    end
    if (!hit) begin
      ram_q.push_back(a & ~32'h3);
      mem_lat = l;
    end
    if_read  = 1'b1;
    if_addr  = a;
    ram_busy = !hit && (b > 0);
    @(posedge clock); #1;
    if_read = 1'b0;
    if_addr = $urandom;
    if (!hit) begin
      for (int i = 0; i < b; i++) begin
        chk("busy_no_ram_read", {31'd0, ram_read}, 32'd0);
        @(posedge clock); #1;
      end
      ram_busy = 1'b0;
      if (cach && install) begin
        mv[idx] = 1'b1;
        mt[idx] = tg;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_d.size() != 0 || ram_q.size() != 0 || if_busy || ram_ready) && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (n >= 400) begin
      tests++;
      fails++;
      $display("FAIL wait_idle_timeout: got %0d pending responses %0d pending reads, required 0 and 0",
               exp_d.size(), ram_q.size());
      exp_d.delete();
      exp_c.delete();
      ram_q.delete();
    end
    @(posedge clock); #1;
  endtask

  task automatic wait_ram_read();
    int n;
    n = 0;
    while (!ram_read && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL ram_read_timeout: got ram_read 0 after %0d cycles, required 1", n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  initial begin
    bit          h;
    logic [31:0] a;
    int          k;
    model_clear();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
    chk("rst_if_busy",  {31'd0, if_busy},  32'd0);
    chk("rst_ram_read", {31'd0, ram_read}, 32'd0);
    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_if_data",  if_data,  32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Cold miss then hit on 0x0.
    issue(32'h0, 0, 4, 1, 1, 0, h); wait_idle();
    issue(32'h0, 0, 4, 1, 1, 0, h); wait_idle();

    // Abort in IDLE cancels a same-cycle hit.
    if_read = 1'b1; if_addr = 32'h0; abort = 1'b1;
    @(posedge clock); #1;
    if_read = 1'b0; abort = 1'b0;
    chk("abort_idle_no_pulse", {31'd0, if_ready}, 32'd0);
    @(posedge clock); #1;

    // Conflict on index 0.
    issue(32'h100, 0, 2, 1, 1, 0, h); wait_idle();
    issue(32'h0,   0, 3, 1, 1, 0, h); wait_idle();

    // Back-to-back hits.
    issue(32'h4, 0, 1, 1, 1, 0, h); wait_idle();
    issue(32'h0, 0, 1, 1, 1, 0, h);
    issue(32'h4, 0, 1, 1, 1, 0, h);
    wait_idle();

    // Bus contention for 3 cycles.
    issue(32'h200, 3, 2, 1, 1, 0, h); wait_idle();

    // Abort one cycle into FILL: no pulse, but the line is installed.
    issue(32'h40, 0, 4, 0, 1, 0, h);
    wait_ram_read();
    @(posedge clock); #1 abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    wait_idle();
    issue(32'h40, 0, 4, 1, 1, 0, h); wait_idle();

    // Flush during FILL: word delivered, not installed.
    issue(32'h80, 0, 4, 1, 0, 0, h);
    wait_ram_read();
    @(posedge clock); #1 flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    model_clear();
    wait_idle();
    issue(32'h80, 0, 2, 1, 1, 0, h); wait_idle();

    // Flush in IDLE with a same-cycle request: request becomes a miss next cycle.
    issue(32'h0, 0, 1, 1, 1, 0, h); wait_idle();
    if_read = 1'b1; if_addr = 32'h0; flush = 1'b1;
    @(posedge clock); #1 flush = 1'b0;
    model_clear();
    issue(32'h0, 0, 2, 1, 1, 0, h); wait_idle();

    // Freeze for 5 cycles mid-FILL.
    issue(32'h300, 0, 4, 1, 1, 5, h);
    wait_ram_read();
    @(posedge clock); #1 rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("freeze_ram_read", {31'd0, ram_read}, 32'd1);
      chk("freeze_ram_addr", ram_addr, 32'h300);
      @(posedge clock); #1;
    end
    rdy = 1'b1;
    wait_idle();

    // Reset mid-FILL.
    issue(32'h400, 0, 4, 0, 0, 0, h);
    wait_ram_read();
    #1 reset = 1'b1;
    #1;
    chk("reset_ram_read_async", {31'd0, ram_read}, 32'd0);
    chk("reset_if_busy_async",  {31'd0, if_busy},  32'd0);
    @(posedge clock); #1 reset = 1'b0;
    model_clear();
    ram_q.delete();
    exp_d.delete();
    exp_c.delete();
    @(posedge clock); #1;
    issue(32'h0,   0, 1, 1, 1, 0, h); wait_idle();
    issue(32'h400, 0, 1, 1, 1, 0, h); wait_idle();

    // Randomized traffic.
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 19) == 0) begin
        flush = 1'b1;
        @(posedge clock); #1 flush = 1'b0;
        model_clear();
      end else begin
        k = $urandom_range(0, 9);
        if (k == 0)      a = 32'h0002_0000 + $urandom_range(0, 255) * 4;
        else if (k == 1) a = 32'h0001_FFFC;
        else if (k == 2) a = $urandom | 32'h8000_0000;
        else             a = $urandom_range(0, 3) * 256 + $urandom_range(0, 15) * 4;
        a = a | $urandom_range(0, 3);
        issue(a, $urandom_range(0, 3), $urandom_range(1, 4), 1, 1, 0, h);
        if (!h) wait_idle();
      end
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
